// File: rtl/bypass_scoreboard.sv
// Operand bypass network and long-latency scoreboard for the ID stage.
// Forwards EX/MEM/long-op results combinationally and raises stall on hazards.
module bypass_scoreboard #(
  parameter int N_RS   = 3,
  parameter int N_STG  = 2,
  parameter int ADDR_W = 6,
  parameter int XLEN   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_RS-1:0]          rs_rena,
  input  logic [N_RS*ADDR_W-1:0]   rs_addr,
  input  logic [N_RS*XLEN-1:0]     rs_data_ID,
  input  logic [N_STG-1:0]         rd_wena,
  input  logic [N_STG*ADDR_W-1:0]  rd_addr,
  input  logic [N_STG*XLEN-1:0]    rd_data,
  input  logic [N_STG-1:0]         rd_rdy,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  output logic [N_RS*XLEN-1:0]     rs_data,
  output logic                     stall,
  output logic [31:0]              stall_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic [NREG-1:0] pend_eff;
  logic [31:0]     stall_cnt_q;
  logic [31:0]     stall_cnt_d;

  logic [N_RS-1:0] ld_use;
  logic [N_RS-1:0] raw_hit;
  logic            wb_iss;
  logic            waw;
  logic            do_set;

  // While reset is held the scoreboard is treated as empty.
  always_comb begin
    pend_eff = reset ? '0 : pend_q;
  end

  for (genvar i = 0; i < N_RS; i++) begin : g_port
    logic [ADDR_W-1:0] a;
    logic              act;
    logic [N_STG-1:0]  hit;
    logic              any;
    logic              sel_rdy;
    logic              wbf;
    logic [XLEN-1:0]   fwd;

    assign a   = rs_addr[i*ADDR_W +: ADDR_W];
    assign act = rs_rena[i] & (a != '0);
    assign wbf = act & wb_valid & (wb_addr == a);

    always_comb begin
      hit = '0;
      for (int j = 0; j < N_STG; j++) begin
        hit[j] = act & rd_wena[j] &
                 (rd_addr[j*ADDR_W +: ADDR_W] == a);
      end
    end

    // Descending scan so the youngest matching stage wins.
    always_comb begin
      any     = 1'b0;
      sel_rdy = 1'b1;
      fwd     = rs_data_ID[i*XLEN +: XLEN];
      if (wbf) begin
        fwd = wb_data;
      end
      for (int j = N_STG - 1; j >= 0; j--) begin
        if (hit[j]) begin
          any     = 1'b1;
          sel_rdy = rd_rdy[j];
          fwd     = rd_data[j*XLEN +: XLEN];
        end
      end
    end

    assign rs_data[i*XLEN +: XLEN] = fwd;
    assign ld_use[i]  = any & ~sel_rdy;
    assign raw_hit[i] = act & pend_eff[a] & ~wbf;
  end

  assign wb_iss = wb_valid & (wb_addr == issue_addr);
  assign waw    = issue_valid & pend_eff[issue_addr] & ~wb_iss;
  assign stall  = (|ld_use) | (|raw_hit) | waw;
  assign do_set = issue_valid & ~stall & (issue_addr != '0);

  // Clear before set so a same-cycle issue keeps the bit.
  always_comb begin
    pend_d = pend_q;
    if (wb_valid) begin
      pend_d[wb_addr] = 1'b0;
    end
    if (do_set) begin
      pend_d[issue_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Scoreboard bench for bypass_scoreboard: expectations queued on drive,
// DUT snapshots queued on sample, both drained and compared per scenario.
module tb_bypass_scoreboard;

  localparam int NRS = 3;
  localparam int NSTG = 2;
  localparam int AW = 6;
  localparam int XL = 32;

  logic                 clk;
  logic                 reset;
  logic [NRS-1:0]       rs_rena;
  logic [NRS*AW-1:0]    rs_addr;
  logic [NRS*XL-1:0]    rs_data_ID;
  logic [NSTG-1:0]      rd_wena;
  logic [NSTG*AW-1:0]   rd_addr;
  logic [NSTG*XL-1:0]   rd_data;
  logic [NSTG-1:0]      rd_rdy;
  logic                 issue_valid;
  logic [AW-1:0]        issue_addr;
  logic                 wb_valid;
  logic [AW-1:0]        wb_addr;
  logic [XL-1:0]        wb_data;
  logic [NRS*XL-1:0]    rs_data;
  logic                 stall;
  logic [31:0]          stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 0;

  typedef struct {
    string       nm;
    int          port;
    logic [31:0] data;
    logic        stl;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic        stl;
  } obs_t;

  exp_t sb[$];
  obs_t ob[$];

  bypass_scoreboard #(
    .N_RS(NRS), .N_STG(NSTG), .ADDR_W(AW), .XLEN(XL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rs_rena(rs_rena),
    .rs_addr(rs_addr),
    .rs_data_ID(rs_data_ID),
    .rd_wena(rd_wena),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_rdy(rd_rdy),
    .issue_valid(issue_valid),
    .issue_addr(issue_addr),
    .wb_valid(wb_valid),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .rs_data(rs_data),
    .stall(stall),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] idv(input int i);
    return 32'hD000_0000 + 32'(i);
  endfunction

  task automatic clr();
    rs_rena     = '0;
    rs_addr     = '0;
    rd_wena     = '0;
    rd_addr     = '0;
    rd_data     = '0;
    rd_rdy      = '1;
    issue_valid = 1'b0;
    issue_addr  = '0;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
  endtask

  task automatic rd_port(input int i, input logic [AW-1:0] a);
    rs_rena[i]         = 1'b1;
    rs_addr[i*AW +: AW] = a;
  endtask

  task automatic stg(input int j, input logic [AW-1:0] a,
                     input logic [31:0] d, input logic rdy);
    rd_wena[j]          = 1'b1;
    rd_addr[j*AW +: AW] = a;
    rd_data[j*XL +: XL] = d;
    rd_rdy[j]           = rdy;
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
  endtask

  task automatic iss(input logic [AW-1:0] a);
    issue_valid = 1'b1;
    issue_addr  = a;
  endtask

  task automatic push(input string nm, input int p,
                      input logic [31:0] d, input logic s);
    exp_t e;
    e.nm = nm;
    e.port = p;
    e.data = d;
    e.stl = s;
    sb.push_back(e);
  endtask

  // Settle, snapshot outputs for queued expectations, then clock.
  task automatic tick(input logic exp_stall);
    obs_t o;
    #1;
    while (ob.size() < sb.size()) begin
      o.data = rs_data[sb[ob.size()].port*XL +: XL];
      o.stl  = stall;
      ob.push_back(o);
    end
    if (exp_stall) exp_cnt = exp_cnt + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    obs_t o;
    reset = 1'b1;
    clr();
    tick(1'b0);
    tick(1'b0);
    reset = 1'b0;
    exp_cnt = 0;
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_cnt: got %h want 0", stall_cnt);
    end
    rd_port(0, 6'd1);
    rd_port(1, 6'd2);
    rd_port(2, 6'd33);
    push("rst_p0", 0, idv(0), 1'b0);
    push("rst_p1", 1, idv(1), 1'b0);
    push("rst_p2", 2, idv(2), 1'b0);
    tick(1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = ob.pop_front();
      checks++;
      if (o.data !== e.data || o.stl !== e.stl) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b",
                 e.nm, o.data, o.stl, e.data, e.stl);
      end
    end
  endtask

  task automatic test_forward();
    exp_t e;
    obs_t o;
    clr();
    stg(0, 6'd5, 32'hA, 1'b1);
    stg(1, 6'd5, 32'hB, 1'b1);
    rd_port(0, 6'd5);
    rd_port(1, 6'd6);
    push("fwd_s0", 0, 32'hA, 1'b0);
    push("fwd_none", 1, idv(1), 1'b0);
    tick(1'b0);
    clr();
    stg(1, 6'd5, 32'hB, 1'b1);
    rd_port(1, 6'd5);
    wb(6'd12, 32'h55);
    rd_port(2, 6'd12);
    rd_port(0, 6'd13);
    push("fwd_s1", 1, 32'hB, 1'b0);
    push("fwd_wb", 2, 32'h55, 1'b0);
    push("fwd_wb_miss", 0, idv(0), 1'b0);
    tick(1'b0);
    clr();
    stg(0, 6'd5, 32'hA, 1'b1);
    wb(6'd5, 32'h66);
    rd_port(2, 6'd5);
    rs_addr[0 +: AW] = 6'd5;
    push("fwd_stage_over_wb", 2, 32'hA, 1'b0);
    push("fwd_disabled", 0, idv(0), 1'b0);
    tick(1'b0);
    clr();
    stg(0, 6'd32, 32'hC, 1'b1);
    rd_port(1, 6'd32);
    push("fwd_fp32", 1, 32'hC, 1'b0);
    tick(1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = ob.pop_front();
      checks++;
      if (o.data !== e.data || o.stl !== e.stl) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b",
                 e.nm, o.data, o.stl, e.data, e.stl);
      end
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    obs_t o;
    for (int k = 0; k < 3; k++) begin
      clr();
      stg(0, 6'd7, 32'h77, 1'b0);
      rd_port(1, 6'd7);
      push("lu_stall", 1, 32'h77, 1'b1);
      tick(1'b1);
    end
    checks++;
    if (stall_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
    clr();
    stg(0, 6'd7, 32'h70, 1'b1);
    stg(1, 6'd7, 32'h71, 1'b0);
    rd_port(1, 6'd7);
    push("lu_youngest_ready", 1, 32'h70, 1'b0);
    tick(1'b0);
    clr();
    stg(0, 6'd7, 32'h77, 1'b0);
    rs_addr[1*AW +: AW] = 6'd7;
    push("lu_disabled", 1, idv(1), 1'b0);
    tick(1'b0);
    clr();
    stg(0, 6'd8, 32'h80, 1'b1);
    stg(1, 6'd7, 32'h71, 1'b0);
    rd_port(0, 6'd7);
    push("lu_stage1", 0, 32'h71, 1'b1);
    tick(1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = ob.pop_front();
      checks++;
      if (o.data !== e.data || o.stl !== e.stl) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b",
                 e.nm, o.data, o.stl, e.data, e.stl);
      end
    end
  endtask

  task automatic test_raw();
    exp_t e;
    obs_t o;
    clr();
    iss(6'd9);
    push("raw_issue", 0, idv(0), 1'b0);
    tick(1'b0);
    for (int k = 0; k < 2; k++) begin
      clr();
      rd_port(2, 6'd9);
      push("raw_wait", 2, idv(2), 1'b1);
      tick(1'b1);
    end
    clr();
    rd_port(2, 6'd9);
    wb(6'd9, 32'h1234);
    push("raw_wb_fwd", 2, 32'h1234, 1'b0);
    tick(1'b0);
    clr();
    rd_port(2, 6'd9);
    push("raw_cleared", 2, idv(2), 1'b0);
    tick(1'b0);
    checks++;
    if (stall_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL raw_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = ob.pop_front();
      checks++;
      if (o.data !== e.data || o.stl !== e.stl) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b",
                 e.nm, o.data, o.stl, e.data, e.stl);
      end
    end
  endtask

  task automatic test_waw();
    exp_t e;
    obs_t o;
    clr();
    iss(6'd40);
    push("waw_first", 0, idv(0), 1'b0);
    tick(1'b0);
    clr();
    iss(6'd40);
    push("waw_stall", 0, idv(0), 1'b1);
    tick(1'b1);
    clr();
    iss(6'd40);
    wb(6'd40, 32'h4040);
    rd_port(1, 6'd40);
    push("waw_wb_same", 1, 32'h4040, 1'b0);
    tick(1'b0);
    clr();
    rd_port(0, 6'd40);
    iss(6'd41);
    push("waw_still_pend", 0, idv(0), 1'b1);
    tick(1'b1);
    clr();
    rd_port(0, 6'd41);
    push("stalled_issue_ignored", 0, idv(0), 1'b0);
    tick(1'b0);
    clr();
    wb(6'd40, 32'h0);
    tick(1'b0);
    clr();
    rd_port(0, 6'd40);
    push("waw_cleared", 0, idv(0), 1'b0);
    tick(1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = ob.pop_front();
      checks++;
      if (o.data !== e.data || o.stl !== e.stl) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b",
                 e.nm, o.data, o.stl, e.data, e.stl);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    obs_t o;
    clr();
    iss(6'd20);
    wb(6'd20, 32'h2020);
    push("b2b_set_wb", 0, idv(0), 1'b0);
    tick(1'b0);
    clr();
    rd_port(2, 6'd20);
    iss(6'd21);
    push("b2b_set_wins", 2, idv(2), 1'b1);
    tick(1'b1);
    clr();
    wb(6'd20, 32'h0);
    iss(6'd22);
    tick(1'b0);
    clr();
    rd_port(0, 6'd20);
    rd_port(1, 6'd22);
    push("b2b_cleared", 0, idv(0), 1'b1);
    tick(1'b1);
    clr();
    wb(6'd22, 32'h0);
    tick(1'b0);
    clr();
    rd_port(0, 6'd20);
    rd_port(1, 6'd22);
    push("b2b_all_clear", 1, idv(1), 1'b0);
    tick(1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = ob.pop_front();
      checks++;
      if (o.data !== e.data || o.stl !== e.stl) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b",
                 e.nm, o.data, o.stl, e.data, e.stl);
      end
    end
  endtask

  task automatic test_zero();
    exp_t e;
    obs_t o;
    clr();
    stg(0, 6'd0, 32'hFFFF, 1'b0);
    rd_port(0, 6'd0);
    iss(6'd0);
    wb(6'd0, 32'hEEEE);
    push("zero_no_fwd", 0, idv(0), 1'b0);
    tick(1'b0);
    clr();
    iss(6'd0);
    rd_port(1, 6'd0);
    push("zero_not_pend", 1, idv(1), 1'b0);
    tick(1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = ob.pop_front();
      checks++;
      if (o.data !== e.data || o.stl !== e.stl) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b",
                 e.nm, o.data, o.stl, e.data, e.stl);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    obs_t o;
    clr();
    iss(6'd3);
    tick(1'b0);
    clr();
    iss(6'd4);
    tick(1'b0);
    clr();
    rd_port(0, 6'd3);
    push("mid_pend3", 0, idv(0), 1'b1);
    tick(1'b1);
    reset = 1'b1;
    clr();
    rd_port(0, 6'd4);
    iss(6'd5);
    push("mid_rst_empty", 0, idv(0), 1'b0);
    tick(1'b0);
    clr();
    stg(0, 6'd7, 32'h77, 1'b0);
    rd_port(1, 6'd7);
    push("mid_rst_lu", 1, 32'h77, 1'b1);
    tick(1'b0);
    reset = 1'b0;
    exp_cnt = 0;
    checks++;
    if (stall_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL mid_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
    clr();
    rd_port(0, 6'd3);
    rd_port(1, 6'd4);
    rd_port(2, 6'd5);
    push("mid_x3", 0, idv(0), 1'b0);
    push("mid_x5", 2, idv(2), 1'b0);
    tick(1'b0);
    clr();
    wb(6'd3, 32'h3);
    tick(1'b0);
    clr();
    rd_port(0, 6'd3);
    push("mid_late_wb", 0, idv(0), 1'b0);
    tick(1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = ob.pop_front();
      checks++;
      if (o.data !== e.data || o.stl !== e.stl) begin
        errors++;
        $display("FAIL %s: got %h/%b want %h/%b",
                 e.nm, o.data, o.stl, e.data, e.stl);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clr();
    for (int i = 0; i < NRS; i++) begin
      rs_data_ID[i*XL +: XL] = idv(i);
    end
    test_reset();
    test_forward();
    test_load_use();
    test_raw();
    test_waw();
    test_back_to_back();
    test_zero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
